// File: rtl/garbage_collector_if.sv
// Flash-side bus of the garbage collector: used-block count, grant, host
// contention and the command/address handshake toward the flash controller.
interface garbage_collector_if #(
  parameter int BW = 8,
  parameter int PW = 2
);
  logic [BW-1:0]    W_used;
  logic [BW-1:0]    free_blk;
  logic             gc_start;
  logic             gc_ini;
  logic             host_req;
  logic             flash_ready;
  logic             gc_request;
  logic             gc_interrupt;
  logic             req_done;
  logic             flash_cmd_valid;
  logic [1:0]       flash_cmd;
  logic [BW+PW-1:0] flash_addr;
  logic [BW-1:0]    victim;

  modport master (
    input  W_used, free_blk, gc_start, gc_ini, host_req, flash_ready,
    output gc_request, gc_interrupt, req_done, flash_cmd_valid, flash_cmd,
           flash_addr, victim
  );

  modport slave (
    output W_used, free_blk, gc_start, gc_ini, host_req, flash_ready,
    input  gc_request, gc_interrupt, req_done, flash_cmd_valid, flash_cmd,
           flash_addr, victim
  );
endinterface

// File: rtl/garbage_collector.sv
// Reclaims one victim block at a time: copies each page to free_blk, erases
// the victim, and yields the flash to the host between pages.
module garbage_collector #(
  parameter int BW     = 8,
  parameter int PW     = 2,
  parameter int THRESH = 200
) (
  input  logic                CLK,
  input  logic                nRST,
  garbage_collector_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_READ, S_PROG, S_ERASE, S_DONE, S_YIELD
  } state_t;

  localparam logic [BW-1:0] THRESH_V  = BW'(THRESH);
  localparam logic [PW-1:0] LAST_PAGE = '1;

  state_t           state_q, state_d;
  logic [BW-1:0]    victim_q, victim_d;
  logic [BW-1:0]    dst_q, dst_d;
  logic [PW-1:0]    page_q, page_d;
  logic             intr_q, intr_d;
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic [BW+PW-1:0] addr;
  logic             hs;

  assign hs = cmd_valid && bus.flash_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
      dst_q    <= '0;
      page_q   <= '0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      dst_q    <= dst_d;
      page_q   <= page_d;
      intr_q   <= intr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    dst_d    = dst_q;
    page_d   = page_q;
    intr_d   = 1'b0;
    if (bus.gc_ini) begin
      state_d  = S_IDLE;
      victim_d = '0;
      page_d   = '0;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.W_used >= THRESH_V) state_d = S_REQ;
        S_REQ:   if (bus.gc_start) state_d = S_READ;
        S_READ: begin
          // Destination captured here so the PROG address cannot move mid-command.
          if (hs) begin
            state_d = S_PROG;
            dst_d   = bus.free_blk;
          end
        end
        S_PROG: begin
          if (hs) begin
            if (page_q == LAST_PAGE) begin
              state_d = S_ERASE;
            end else begin
              page_d = page_q + 1'b1;
              if (bus.host_req) begin
                state_d = S_YIELD;
                intr_d  = 1'b1;
              end else begin
                state_d = S_READ;
              end
            end
          end
        end
        S_YIELD: if (!bus.host_req) state_d = S_REQ;
        S_ERASE: if (hs) state_d = S_DONE;
        S_DONE: begin
          state_d  = S_IDLE;
          page_d   = '0;
          victim_d = victim_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    addr      = '0;
    case (state_q)
      S_READ: begin
        cmd_valid = 1'b1;
        cmd       = 2'b01;
        addr      = {victim_q, page_q};
      end
      S_PROG: begin
        cmd_valid = 1'b1;
        cmd       = 2'b10;
        addr      = {dst_q, page_q};
      end
      S_ERASE: begin
        cmd_valid = 1'b1;
        cmd       = 2'b11;
        addr      = {victim_q, {PW{1'b0}}};
      end
      default: ;
    endcase
  end

  assign bus.flash_cmd_valid = cmd_valid;
  assign bus.flash_cmd       = cmd;
  assign bus.flash_addr      = addr;
  assign bus.victim          = victim_q;
  assign bus.gc_request      = (state_q == S_REQ);
  // A re-initialise in the same cycle suppresses both pulses.
  assign bus.gc_interrupt    = intr_q && !bus.gc_ini;
  assign bus.req_done        = (state_q == S_DONE) && !bus.gc_ini;
endmodule

// File: doc/garbage_collector.md
GARBAGE_COLLECTOR -- requirements
Module: garbage_collector

Interface
REQ-001 Parameter BW SHALL default to 8 and sets the block address width.
REQ-002 Parameter PW SHALL default to 2 and sets the page-in-block width, giving 4 pages per block.
REQ-003 Parameter THRESH SHALL default to 200 and sets the used-block count that triggers GC.
REQ-004 Port CLK SHALL be an input, 1 bit: the single clock; all logic is posedge CLK.
REQ-005 Port nRST SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port W_used SHALL be an input, BW bits: current used-block count from the flash side.
REQ-007 Port free_blk SHALL be an input, BW bits: destination block for relocated pages.
REQ-008 Port gc_start SHALL be an input, 1 bit: grant from the flash controller.
REQ-009 Port gc_ini SHALL be an input, 1 bit: synchronous GC re-initialise command from the flash controller.
REQ-010 Port host_req SHALL be an input, 1 bit: a host access is pending, and GC must yield.
REQ-011 Port flash_ready SHALL be an input, 1 bit: the flash accepts the presented command.
REQ-012 Port gc_request SHALL be an output, 1 bit: GC wants ownership of the flash.
REQ-013 Port gc_interrupt SHALL be an output, 1 bit: 1-cycle pulse, GC paused for the host.
REQ-014 Port req_done SHALL be an output, 1 bit: 1-cycle pulse, victim block reclaimed.
REQ-015 Port flash_cmd_valid SHALL be an output, 1 bit: a command is presented.
REQ-016 Port flash_cmd SHALL be an output, 2 bits: 01 READ, 10 PROG, 11 ERASE, 00 when idle.
REQ-017 Port flash_addr SHALL be an output, BW+PW bits: {block, page}.
REQ-018 Port victim SHALL be an output, BW bits: current victim block pointer.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, READ, PROG, ERASE, DONE and YIELD.
REQ-020 flash_cmd_valid, flash_cmd and flash_addr SHALL be Moore outputs decoded from state.
REQ-021 flash_cmd_valid, flash_cmd and flash_addr SHALL be held stable until a handshake occurs.
REQ-022 A handshake SHALL be flash_cmd_valid and flash_ready both high at a posedge.
REQ-023 IDLE: when W_used >= THRESH, the FSM SHALL go to REQ; otherwise it stays in IDLE.
REQ-024 REQ: gc_request SHALL be 1 and held, even if W_used drops, until gc_start is sampled high; the FSM then goes to READ.
REQ-025 gc_start outside REQ SHALL be ignored.
REQ-026 READ: the block SHALL present cmd=01 with addr={victim, page}; on handshake it goes to PROG.
REQ-027 PROG: the block SHALL present cmd=10 with addr={free_blk, page}. On handshake:
- if page equals all-ones, it goes to ERASE;
- otherwise page increments, then it goes to YIELD if host_req=1, else to READ.
REQ-028 When a handshake occurs on the last page of a block, host_req SHALL be ignored; erase proceeds.
REQ-029 YIELD: gc_interrupt SHALL pulse for exactly 1 cycle on entry; the FSM waits until host_req=0, then goes to REQ.
REQ-030 After a yield, the page counter SHALL be retained, and copying resumes at the saved page.
REQ-031 ERASE: the block SHALL present cmd=11 with addr={victim, 0}; on handshake it goes to DONE.
REQ-032 DONE: req_done SHALL be high for exactly 1 cycle, page SHALL clear to 0, and victim SHALL increment modulo 2^BW (255 wraps to 0); next state is IDLE.
REQ-033 Latency from gc_start to the first READ valid SHALL be 1 cycle.
REQ-034 gc_ini=1 SHALL have the highest priority in every state: next state IDLE, victim=0, page=0, and no pulses that cycle.
REQ-035 Outside REQ, gc_request SHALL be 0.
REQ-036 In IDLE, REQ, YIELD and DONE, flash_cmd_valid SHALL be 0.

Reset
REQ-037 nRST low SHALL immediately force state IDLE, victim=0, page=0, and all outputs 0, including mid-command.
REQ-038 After nRST deasserts, the block SHALL operate from IDLE with no recovery of the interrupted block.

Verification
REQ-039 Normal reclaim: W_used=200, gc_start after 3 cycles, flash_ready tied 1, free_blk=9 -> commands:
- READ 0x00;
- PROG 0x24;
- READ 0x01;
- PROG 0x25;
- ... through page 3;
- ERASE 0x00;
- then a req_done pulse and victim=1.
REQ-040 Threshold boundary: W_used=199 for 20 cycles -> gc_request stays 0; W_used=200 -> gc_request=1 on the next cycle.
REQ-041 Yield: host_req=1 during the PROG of page 1 -> 1-cycle gc_interrupt pulse; after host_req=0 and a new gc_start, the block presents READ with addr {victim,2}.
REQ-042 Backpressure and last page: flash_ready=0 for 5 cycles in READ -> cmd and addr stay stable; host_req=1 at the page-3 PROG handshake -> ERASE follows and there is no gc_interrupt.
REQ-043 Wrap: victim=255 reclaim -> victim=0 after req_done.
REQ-044 Abort paths:
- gc_ini in PROG -> IDLE with victim=0 and no req_done;
- nRST low mid-ERASE -> flash_cmd_valid=0 immediately.
